// File: rtl/mbinit_cal_module_initiator.sv
// rtl/mbinit_cal_module_initiator.sv - MBINIT.CAL initiator: sends Done_req, waits for Done_resp, bounded by a timeout
module mbinit_cal_module_initiator #(
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       i_MBINIT_PARAM_end,
    input  logic [3:0] i_RX_SbMessage,
    input  logic       i_msg_valid,
    input  logic       i_Busy_SideBand,
    input  logic       i_falling_edge_busy,
    output logic [3:0] o_TX_SbMessage,
    output logic       o_ValidOutDatat_Module,
    output logic       o_MBINIT_CAL_Module_end,
    output logic       o_timeout_error
);

    localparam logic [3:0]       MSG_DONE_REQ  = 4'b0001;
    localparam logic [3:0]       MSG_DONE_RESP = 4'b0010;
    localparam logic [CNT_W-1:0] TIMER_MAX     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMER_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SB_FREE,
        SEND_REQ,
        WAIT_RESP,
        DONE,
        ERROR
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] timer, timer_next;
    logic             resp_seen, resp_seen_next;
    logic [3:0]       tx_msg_next;
    logic             tx_valid_next, cal_end_next, timeout_next;
    logic             resp_now, timed_out;
    logic [CNT_W-1:0] timer_inc;

    assign resp_now  = i_msg_valid && (i_RX_SbMessage == MSG_DONE_RESP);
    assign timed_out = timer >= TIMER_LAST;
    assign timer_inc = (timer == TIMER_MAX) ? timer : timer + CNT_W'(1);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            timer                   <= '0;
            resp_seen               <= 1'b0;
            o_TX_SbMessage          <= 4'b0000;
            o_ValidOutDatat_Module  <= 1'b0;
            o_MBINIT_CAL_Module_end <= 1'b0;
            o_timeout_error         <= 1'b0;
        end else begin
            state                   <= next_state;
            timer                   <= timer_next;
            resp_seen               <= resp_seen_next;
            o_TX_SbMessage          <= tx_msg_next;
            o_ValidOutDatat_Module  <= tx_valid_next;
            o_MBINIT_CAL_Module_end <= cal_end_next;
            o_timeout_error         <= timeout_next;
        end
    end

    always_comb begin
        next_state     = state;
        timer_next     = timer;
        resp_seen_next = resp_seen;
        if (!i_MBINIT_PARAM_end) begin
            next_state     = IDLE;
            timer_next     = '0;
            resp_seen_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    next_state     = WAIT_SB_FREE;
                    timer_next     = '0;
                    resp_seen_next = 1'b0;
                end
                WAIT_SB_FREE: begin
                    timer_next = '0;
                    if (!i_Busy_SideBand)
                        next_state = SEND_REQ;
                end
                SEND_REQ: begin
                    timer_next = timer_inc;
                    if (resp_now)
                        resp_seen_next = 1'b1;
                    // TX completion takes priority over the timer expiring in the same cycle
                    if (i_falling_edge_busy)
                        next_state = (resp_seen || resp_now) ? DONE : WAIT_RESP;
                    else if (timed_out)
                        next_state = ERROR;
                end
                WAIT_RESP: begin
                    timer_next = timer_inc;
                    if (resp_now)
                        next_state = DONE;
                    else if (timed_out)
                        next_state = ERROR;
                end
                DONE, ERROR: ;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are registered from next_state so they line up with the state itself
    always_comb begin
        tx_valid_next = (next_state == SEND_REQ);
        tx_msg_next   = tx_valid_next ? MSG_DONE_REQ : 4'b0000;
        cal_end_next  = (next_state == DONE);
        timeout_next  = (next_state == ERROR);
    end

endmodule

// File: tb/tb_mbinit_cal_module_initiator.sv
// tb/tb_mbinit_cal_module_initiator.sv - directed self-checking bench for mbinit_cal_module_initiator
module tb_mbinit_cal_module_initiator;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] rx_msg;
    logic       msg_valid;
    logic       busy;
    logic       fall;
    logic [3:0] tx_msg;
    logic       tx_valid;
    logic       cal_end;
    logic       to_err;

    int checks = 0;
    int passes = 0;

    mbinit_cal_module_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .CLK                     (CLK),
        .rst_n                   (rst_n),
        .i_MBINIT_PARAM_end      (en),
        .i_RX_SbMessage          (rx_msg),
        .i_msg_valid             (msg_valid),
        .i_Busy_SideBand         (busy),
        .i_falling_edge_busy     (fall),
        .o_TX_SbMessage          (tx_msg),
        .o_ValidOutDatat_Module  (tx_valid),
        .o_MBINIT_CAL_Module_end (cal_end),
        .o_timeout_error         (to_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        fall      = 1'b0;
        msg_valid = 1'b0;
        rx_msg    = 4'b0000;
    endtask

    task automatic go_idle();
        en   = 1'b0;
        busy = 1'b0;
        clear_inputs();
        step();
        step();
    endtask

    // Leaves the DUT in the first SEND_REQ cycle (k=0)
    task automatic enter_send_req();
        go_idle();
        en = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        busy  = 1'b0;
        clear_inputs();
        step();
        step();
        checks++; if (tx_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", tx_valid); else passes++;
        checks++; if (tx_msg !== 4'b0000) $display("FAIL reset_msg got %b exp 0000", tx_msg); else passes++;
        checks++; if (cal_end !== 1'b0) $display("FAIL reset_end got %b exp 0", cal_end); else passes++;
        checks++; if (to_err !== 1'b0) $display("FAIL reset_err got %b exp 0", to_err); else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        go_idle();
        en = 1'b1;
        step();
        checks++; if (tx_valid !== 1'b0) $display("FAIL nom_wsf_valid got %b exp 0", tx_valid); else passes++;
        step();
        for (int k = 0; k < 7; k++) begin
            checks++; if (tx_valid !== (k < 3)) $display("FAIL nom_valid k=%0d got %b exp %b", k, tx_valid, (k < 3)); else passes++;
            checks++; if (tx_msg !== ((k < 3) ? 4'b0001 : 4'b0000)) $display("FAIL nom_msg k=%0d got %b", k, tx_msg); else passes++;
            checks++; if (cal_end !== 1'b0) $display("FAIL nom_end_early k=%0d got %b exp 0", k, cal_end); else passes++;
            if (k == 2) fall = 1'b1;
            if (k == 6) begin msg_valid = 1'b1; rx_msg = 4'b0010; end
            step();
            clear_inputs();
        end
        for (int k = 7; k < 10; k++) begin
            checks++; if (cal_end !== 1'b1) $display("FAIL nom_end k=%0d got %b exp 1", k, cal_end); else passes++;
            checks++; if (to_err !== 1'b0) $display("FAIL nom_err k=%0d got %b exp 0", k, to_err); else passes++;
            checks++; if (tx_valid !== 1'b0) $display("FAIL nom_valid_done k=%0d got %b exp 0", k, tx_valid); else passes++;
            step();
        end
    endtask

    // Busy for 5 cycles, then no TX completion: SEND_REQ itself times out 16 cycles after entry
    task automatic test_sideband_busy();
        go_idle();
        en   = 1'b1;
        busy = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (tx_valid !== 1'b0) $display("FAIL busy_valid i=%0d got %b exp 0", i, tx_valid); else passes++;
            if (i == 4) busy = 1'b0;
            step();
        end
        for (int k = 0; k < 16; k++) begin
            checks++; if (tx_valid !== 1'b1) $display("FAIL busy_send_valid k=%0d got %b exp 1", k, tx_valid); else passes++;
            checks++; if (to_err !== 1'b0) $display("FAIL busy_err_early k=%0d got %b exp 0", k, to_err); else passes++;
            step();
        end
        checks++; if (to_err !== 1'b1) $display("FAIL send_timeout_err got %b exp 1", to_err); else passes++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL send_timeout_valid got %b exp 0", tx_valid); else passes++;
        checks++; if (tx_msg !== 4'b0000) $display("FAIL send_timeout_msg got %b exp 0000", tx_msg); else passes++;
        checks++; if (cal_end !== 1'b0) $display("FAIL send_timeout_end got %b exp 0", cal_end); else passes++;
    endtask

    task automatic test_early_response();
        enter_send_req();
        msg_valid = 1'b1;
        rx_msg    = 4'b0010;
        step();
        clear_inputs();
        checks++; if (tx_valid !== 1'b1) $display("FAIL early_still_send got %b exp 1", tx_valid); else passes++;
        checks++; if (cal_end !== 1'b0) $display("FAIL early_end_before got %b exp 0", cal_end); else passes++;
        step();
        fall = 1'b1;
        step();
        clear_inputs();
        checks++; if (cal_end !== 1'b1) $display("FAIL early_end got %b exp 1", cal_end); else passes++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL early_valid got %b exp 0", tx_valid); else passes++;
        // Response and TX completion in the same cycle
        enter_send_req();
        fall      = 1'b1;
        msg_valid = 1'b1;
        rx_msg    = 4'b0010;
        step();
        clear_inputs();
        checks++; if (cal_end !== 1'b1) $display("FAIL simul_end got %b exp 1", cal_end); else passes++;
        checks++; if (to_err !== 1'b0) $display("FAIL simul_err got %b exp 0", to_err); else passes++;
    endtask

    task automatic test_timeout();
        enter_send_req();
        fall = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++; if (to_err !== 1'b0) $display("FAIL to_err_early k=%0d got %b exp 0", k, to_err); else passes++;
            step();
            clear_inputs();
        end
        for (int k = 16; k < 19; k++) begin
            checks++; if (to_err !== 1'b1) $display("FAIL to_err k=%0d got %b exp 1", k, to_err); else passes++;
            checks++; if (cal_end !== 1'b0) $display("FAIL to_end k=%0d got %b exp 0", k, cal_end); else passes++;
            step();
        end
        enter_send_req();
        fall = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin msg_valid = 1'b1; rx_msg = 4'b0010; end
            step();
            clear_inputs();
        end
        checks++; if (cal_end !== 1'b1) $display("FAIL to_race_end got %b exp 1", cal_end); else passes++;
        checks++; if (to_err !== 1'b0) $display("FAIL to_race_err got %b exp 0", to_err); else passes++;
    endtask

    task automatic test_abort();
        logic [3:0] junk [3];
        junk[0] = 4'b0001;
        junk[1] = 4'b0000;
        junk[2] = 4'b0011;
        enter_send_req();
        fall = 1'b1;
        step();
        clear_inputs();
        for (int k = 1; k < 10; k++) begin
            if (k <= 3) begin msg_valid = 1'b1; rx_msg = junk[k-1]; end
            step();
            clear_inputs();
            checks++; if (cal_end !== 1'b0 || to_err !== 1'b0 || tx_valid !== 1'b0)
                $display("FAIL abort_ignore k=%0d got end=%b err=%b valid=%b exp 000", k, cal_end, to_err, tx_valid);
            else passes++;
        end
        en        = 1'b0;
        msg_valid = 1'b1;
        rx_msg    = 4'b0010;
        step();
        clear_inputs();
        checks++; if ({tx_msg, tx_valid, cal_end, to_err} !== 7'd0)
            $display("FAIL abort_outputs got msg=%b valid=%b end=%b err=%b exp all 0", tx_msg, tx_valid, cal_end, to_err);
        else passes++;
        step();
        en = 1'b1;
        step();
        step();
        checks++; if (tx_valid !== 1'b1) $display("FAIL rearm_valid got %b exp 1", tx_valid); else passes++;
        checks++; if (tx_msg !== 4'b0001) $display("FAIL rearm_msg got %b exp 0001", tx_msg); else passes++;
        fall = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++; if (to_err !== 1'b0) $display("FAIL rearm_err_early k=%0d got %b exp 0", k, to_err); else passes++;
            step();
            clear_inputs();
        end
        checks++; if (to_err !== 1'b1) $display("FAIL rearm_err got %b exp 1", to_err); else passes++;
    endtask

    // An early response seen before an abort must not carry into the next enable period
    task automatic test_back_to_back();
        enter_send_req();
        msg_valid = 1'b1;
        rx_msg    = 4'b0010;
        step();
        clear_inputs();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        step();
        fall = 1'b1;
        step();
        clear_inputs();
        checks++; if (cal_end !== 1'b0) $display("FAIL b2b_resp_seen_cleared got %b exp 0", cal_end); else passes++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL b2b_valid got %b exp 0", tx_valid); else passes++;
    endtask

    task automatic test_async_reset();
        enter_send_req();
        fall      = 1'b1;
        msg_valid = 1'b1;
        rx_msg    = 4'b0010;
        step();
        clear_inputs();
        checks++; if (cal_end !== 1'b1) $display("FAIL ar_pre_end got %b exp 1", cal_end); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({tx_msg, tx_valid, cal_end, to_err} !== 7'd0)
            $display("FAIL ar_immediate got msg=%b valid=%b end=%b err=%b exp all 0", tx_msg, tx_valid, cal_end, to_err);
        else passes++;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (tx_valid !== 1'b0) $display("FAIL ar_wsf_valid got %b exp 0", tx_valid); else passes++;
        step();
        checks++; if (tx_valid !== 1'b1) $display("FAIL ar_send_valid got %b exp 1", tx_valid); else passes++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_sideband_busy();
        test_early_response();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
